// File: rtl/sha2_pad_multi_pkg.sv
// Shared types and constants for the dual-mode SHA-2 message padder.
package sha2_pad_multi_pkg;

   // FIFO entry: data is MSB-byte first, mask is left-contiguous (mask[7] covers data[63:56]).
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  mask;
   } sha_fifo64_t;

   typedef enum logic {
      Sha256 = 1'b0,
      Sha512 = 1'b1
   } digest_mode_e;

   localparam int unsigned BlockWords = 16;
   localparam int unsigned LenHiSlot  = 14;
   localparam int unsigned WcntW      = $clog2(BlockWords);

   // Slot of the last padding word before the length field.
   localparam logic [WcntW-1:0] LastPadSlot = WcntW'(LenHiSlot - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFifoRx,
      StPad80,
      StPad00,
      StLenHi,
      StLenLo
   } pad_state_e;

endpackage

// File: rtl/sha2_pad_multi_if.sv
// Message FIFO input and padded-word output streams of the padder.
interface sha2_pad_multi_if;
   import sha2_pad_multi_pkg::*;

   logic        fifo_rvalid;
   sha_fifo64_t fifo_rdata;
   logic        fifo_rready;
   logic        shaf_rvalid;
   logic [63:0] shaf_rdata;
   logic        shaf_rready;
   logic        shaf_rlast;

   // Padder side.
   modport master (
      input  fifo_rvalid, fifo_rdata, shaf_rready,
      output fifo_rready, shaf_rvalid, shaf_rdata, shaf_rlast
   );

   // FIFO and compress-engine side.
   modport slave (
      output fifo_rvalid, fifo_rdata, shaf_rready,
      input  fifo_rready, shaf_rvalid, shaf_rdata, shaf_rlast
   );

endinterface

// File: rtl/sha2_pad_byte_merge.sv
// Builds the first padding word: leading message bytes, then 0x80, then zeros.
module sha2_pad_byte_merge
   import sha2_pad_multi_pkg::*;
(
   input  logic [63:0]  data_i,
   input  logic [2:0]   nbytes_i,
   input  digest_mode_e mode_i,
   output logic [63:0]  word_o
);

   logic [63:0] aligned;
   logic [63:0] merged;

   // Work in a 64-bit MSB-first view; a Sha256 word is lifted to the top half.
   always_comb begin
      aligned = (mode_i == Sha512) ? data_i : {data_i[31:0], 32'h0};
      merged  = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < 32'(nbytes_i)) begin
            merged[63 - 8*i -: 8] = aligned[63 - 8*i -: 8];
         end else if (i == 32'(nbytes_i)) begin
            merged[63 - 8*i -: 8] = 8'h80;
         end
      end
      word_o = (mode_i == Sha512) ? merged : {32'h0, merged[63:32]};
   end

endmodule

// File: rtl/sha2_pad_multi.sv
// Dual-mode SHA-2 message padder between the message FIFO and the compress engine.
module sha2_pad_multi
   import sha2_pad_multi_pkg::*;
#(
   parameter bit          EnSha512 = 1'b1,
   parameter int unsigned LenW     = 128
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            sha_en,
   input  logic            hash_start,
   input  logic            hash_process,
   input  logic            hash_done,
   input  logic            digest_mode,
   input  logic [LenW-1:0] message_length,
   output logic            msg_feed_complete,
   sha2_pad_multi_if.master bus
);

   pad_state_e       state_q, state_d;
   logic [WcntW-1:0] wcnt_q, wcnt_d;
   logic [LenW-1:0]  bcnt_q, bcnt_d;
   logic             process_flag_q, process_flag_d;
   digest_mode_e     mode_q, mode_d;

   logic             start_acc;
   logic             is512;
   logic [63:0]      word_data;
   logic             word_full;
   logic             partial;
   logic [2:0]       nbytes;
   logic [LenW-1:0]  len_eff;
   logic [127:0]     len_full;
   logic [63:0]      len_hi, len_lo;
   logic [63:0]      pad80_word;
   logic [63:0]      out_word;
   logic             out_valid, out_last, fifo_pop;
   logic             shaf_hs;

   assign start_acc = sha_en && hash_start;
   assign is512     = (mode_q == Sha512);

   // Per-mode view of the FIFO head and of the length field.
   always_comb begin
      word_data = is512 ? bus.fifo_rdata.data : {32'h0, bus.fifo_rdata.data[31:0]};
      word_full = is512 ? (bus.fifo_rdata.mask == 8'hFF) : (bus.fifo_rdata.mask[3:0] == 4'hF);
      partial   = bus.fifo_rvalid && !word_full;
      len_eff   = message_length;
      if (!is512) len_eff = LenW'(message_length[63:0]);
      nbytes    = is512 ? len_eff[5:3] : {1'b0, len_eff[4:3]};
      len_full  = 128'(len_eff);
      len_hi    = is512 ? len_full[127:64] : {32'h0, len_full[63:32]};
      len_lo    = is512 ? len_full[63:0]   : {32'h0, len_full[31:0]};
   end

   sha2_pad_byte_merge u_merge (
      .data_i   (word_data),
      .nbytes_i (nbytes),
      .mode_i   (mode_q),
      .word_o   (pad80_word)
   );

   // Next state and stream outputs.
   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      out_word  = '0;
      out_last  = 1'b0;
      fifo_pop  = 1'b0;
      case (state_q)
         StIdle: ;
         StFifoRx: begin
            if (partial) begin
               state_d = StPad80;
            end else if (process_flag_q && (bcnt_q == len_eff)) begin
               state_d = StPad80;
            end else begin
               out_valid = bus.fifo_rvalid;
               out_word  = word_data;
               fifo_pop  = bus.fifo_rvalid && bus.shaf_rready;
            end
         end
         StPad80: begin
            out_valid = (nbytes == 3'd0) || bus.fifo_rvalid;
            out_word  = pad80_word;
            fifo_pop  = (nbytes != 3'd0) && bus.fifo_rvalid && bus.shaf_rready;
            if (out_valid && bus.shaf_rready) begin
               state_d = (wcnt_q == LastPadSlot) ? StLenHi : StPad00;
            end
         end
         StPad00: begin
            out_valid = 1'b1;
            if (bus.shaf_rready && (wcnt_q == LastPadSlot)) state_d = StLenHi;
         end
         StLenHi: begin
            out_valid = 1'b1;
            out_word  = len_hi;
            if (bus.shaf_rready) state_d = StLenLo;
         end
         StLenLo: begin
            out_valid = 1'b1;
            out_word  = len_lo;
            out_last  = 1'b1;
            if (bus.shaf_rready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (start_acc) state_d = StFifoRx;
   end

   assign shaf_hs         = out_valid && bus.shaf_rready;
   assign bus.shaf_rvalid = out_valid;
   assign bus.shaf_rlast  = out_last;
   assign bus.fifo_rready = fifo_pop;
   assign bus.shaf_rdata  = EnSha512 ? out_word : {32'h0, out_word[31:0]};
   assign msg_feed_complete = process_flag_q && (state_q == StIdle);

   // Word/bit counters, process flag and latched digest mode.
   always_comb begin
      wcnt_d         = wcnt_q;
      bcnt_d         = bcnt_q;
      process_flag_d = process_flag_q;
      mode_d         = mode_q;
      if (shaf_hs) wcnt_d = wcnt_q + WcntW'(1);
      if (fifo_pop) bcnt_d = bcnt_q + (is512 ? LenW'(64) : LenW'(32));
      if (hash_done || start_acc) process_flag_d = 1'b0;
      if (hash_process) process_flag_d = 1'b1;
      if (start_acc) begin
         wcnt_d = '0;
         bcnt_d = '0;
         mode_d = (EnSha512 && digest_mode) ? Sha512 : Sha256;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         wcnt_q         <= '0;
         bcnt_q         <= '0;
         process_flag_q <= 1'b0;
         mode_q         <= Sha256;
      end else begin
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         bcnt_q         <= bcnt_d;
         process_flag_q <= process_flag_d;
         mode_q         <= mode_d;
      end
   end

endmodule

// File: tb/tb_sha2_pad_multi.sv
// Self-checking bench for sha2_pad_multi against a byte-level SHA-2 padding model.
module tb_sha2_pad_multi;
   import sha2_pad_multi_pkg::*;

   typedef logic [7:0] byte_t;
   typedef byte_t byte_q_t[$];

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sha_en;
   logic         hash_start;
   logic         hash_process;
   logic         hash_done;
   logic         digest_mode;
   logic [127:0] message_length;
   logic         msg_feed_complete;

   int n_checks = 0;
   int n_errors = 0;

   sha2_pad_multi_if bus ();

   sha2_pad_multi #(.EnSha512(1'b1), .LenW(128)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .sha_en            (sha_en),
      .hash_start        (hash_start),
      .hash_process      (hash_process),
      .hash_done         (hash_done),
      .digest_mode       (digest_mode),
      .message_length    (message_length),
      .msg_feed_complete (msg_feed_complete),
      .bus               (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic byte_q_t rand_msg(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(byte_t'($urandom_range(0, 255)));
      return q;
   endfunction

   // Standard SHA-2 padding: msg || 0x80 || zeros || big-endian bit length, cut into words.
   function automatic void ref_pad(input bit m, input byte_q_t msg, output logic [63:0] words[$]);
      int wb = m ? 8 : 4;
      int blk = 16 * wb;
      int lenb = 2 * wb;
      logic [127:0] bits;
      logic [63:0] w;
      byte_q_t s;
      s = msg;
      s.push_back(8'h80);
      while ((s.size() % blk) != (blk - lenb)) s.push_back(8'h00);
      bits = 128'(msg.size()) * 128'd8;
      for (int i = lenb - 1; i >= 0; i--) s.push_back(byte_t'(bits >> (8 * i)));
      words = {};
      for (int k = 0; k < s.size(); k += wb) begin
         w = '0;
         for (int j = 0; j < wb; j++) w = (w << 8) | 64'(s[k + j]);
         words.push_back(w);
      end
   endfunction

   // Pack message bytes into FIFO entries; bytes outside the valid mask get random junk.
   function automatic void build_fifo(input bit m, input byte_q_t msg, output sha_fifo64_t fq[$]);
      int wb = m ? 8 : 4;
      sha_fifo64_t e;
      fq = {};
      for (int k = 0; k < msg.size(); k += wb) begin
         e.data = {$urandom, $urandom};
         e.mask = m ? 8'h00 : {4'($urandom_range(0, 15)), 4'h0};
         for (int j = 0; j < wb && (k + j) < msg.size(); j++) begin
            e.data[(wb * 8 - 1 - 8 * j) -: 8] = msg[k + j];
            e.mask[wb - 1 - j] = 1'b1;
         end
         fq.push_back(e);
      end
   endfunction

   task automatic quiet_inputs();
      hash_start = 1'b0;
      hash_process = 1'b0;
      hash_done = 1'b0;
      bus.fifo_rvalid = 1'b0;
      bus.fifo_rdata = '0;
      bus.shaf_rready = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      quiet_inputs();
      @(posedge clk); #1;
      bus.fifo_rvalid = 1'b1;
      bus.fifo_rdata = '{data: {$urandom, $urandom}, mask: 8'hFF};
      bus.shaf_rready = 1'b1;
      @(negedge clk);
      check_eq("rst_rvalid", 64'(bus.shaf_rvalid), 64'd0);
      check_eq("rst_rdata", bus.shaf_rdata, 64'd0);
      check_eq("rst_rlast", 64'(bus.shaf_rlast), 64'd0);
      check_eq("rst_pop", 64'(bus.fifo_rready), 64'd0);
      check_eq("rst_feed", 64'(msg_feed_complete), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_idle", 64'(bus.shaf_rvalid), 64'd0);
      @(posedge clk); #1;
      quiet_inputs();
   endtask

   // Run one message; abort_at >= 0 abandons it after that many accepted words.
   task automatic run_msg(input bit m, input byte_q_t msg, input int rdy_pct, input int abort_at);
      logic [63:0] exp_q[$];
      sha_fifo64_t fq[$];
      logic [127:0] len;
      logic [63:0] held = '0;
      int idx = 0;
      int cyc = 0;
      int proc_at;
      bit proc_sent = 1'b0;
      bit fv_hold = 1'b0;
      bit stalled = 1'b0;
      bit finished = 1'b0;
      ref_pad(m, msg, exp_q);
      build_fifo(m, msg, fq);
      len = 128'(msg.size()) * 128'd8;
      if (!m) len[127:64] = {$urandom, $urandom, $urandom, $urandom};
      proc_at = $urandom_range(0, fq.size() + 4);
      @(posedge clk); #1;
      quiet_inputs();
      hash_start = 1'b1;
      digest_mode = m;
      message_length = len;
      @(posedge clk); #1;
      hash_start = 1'b0;
      while (!finished && cyc < 4000) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         hash_process = (cyc == proc_at);
         if (cyc == proc_at) proc_sent = 1'b1;
         bus.fifo_rvalid = (fq.size() > 0) && (fv_hold || ($urandom_range(0, 99) < 70));
         bus.fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
         bus.shaf_rready = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clk);
         if (stalled) begin
            check_eq("hold_valid", 64'(bus.shaf_rvalid), 64'd1);
            check_eq("hold_data", bus.shaf_rdata, held);
         end
         if (bus.fifo_rvalid && bus.fifo_rready) begin
            check_eq("pop_needs_hs", 64'(bus.shaf_rvalid && bus.shaf_rready), 64'd1);
         end
         if (bus.shaf_rvalid && bus.shaf_rready) begin
            if (idx < exp_q.size()) begin
               check_eq($sformatf("word%0d", idx), bus.shaf_rdata, exp_q[idx]);
               check_eq($sformatf("rlast%0d", idx), 64'(bus.shaf_rlast), 64'(idx == exp_q.size() - 1));
            end else begin
               check_eq("extra_word", 64'(idx), 64'(exp_q.size() - 1));
            end
            if (bus.shaf_rlast) finished = 1'b1;
            idx++;
            if (idx == abort_at) break;
         end
         if (bus.fifo_rvalid && bus.fifo_rready) begin
            void'(fq.pop_front());
            fv_hold = 1'b0;
         end else begin
            fv_hold = bus.fifo_rvalid;
         end
         stalled = bus.shaf_rvalid && !bus.shaf_rready;
         held = bus.shaf_rdata;
         cyc++;
      end
      if (abort_at >= 0) begin
         check_eq("abort_reached", 64'(idx), 64'(abort_at));
         return;
      end
      check_eq("finished", 64'(finished), 64'd1);
      check_eq("word_count", 64'(idx), 64'(exp_q.size()));
      check_eq("fifo_drained", 64'(fq.size()), 64'd0);
      @(posedge clk); #1;
      quiet_inputs();
      hash_process = !proc_sent;
      // Idle must ignore a valid FIFO word and a start while sha_en is low.
      @(posedge clk); #1;
      hash_process = 1'b0;
      bus.fifo_rvalid = 1'b1;
      bus.fifo_rdata = '{data: {$urandom, $urandom}, mask: 8'hFF};
      bus.shaf_rready = 1'b1;
      sha_en = 1'b0;
      hash_start = 1'b1;
      @(negedge clk);
      check_eq("feed_complete", 64'(msg_feed_complete), 64'd1);
      check_eq("idle_rvalid", 64'(bus.shaf_rvalid), 64'd0);
      check_eq("idle_pop", 64'(bus.fifo_rready), 64'd0);
      @(posedge clk); #1;
      hash_start = 1'b0;
      sha_en = 1'b1;
      @(negedge clk);
      check_eq("gated_start", 64'(bus.shaf_rvalid), 64'd0);
      check_eq("gated_feed", 64'(msg_feed_complete), 64'd1);
      @(posedge clk); #1;
      quiet_inputs();
      hash_done = 1'b1;
      @(posedge clk); #1;
      hash_done = 1'b0;
      @(negedge clk);
      check_eq("feed_clear", 64'(msg_feed_complete), 64'd0);
   endtask

   initial begin
      byte_q_t abc;
      int rm, rl, rr;
      rst_n = 1'b0;
      sha_en = 1'b1;
      digest_mode = 1'b0;
      message_length = '0;
      quiet_inputs();
      abc = {8'h61, 8'h62, 8'h63};
      apply_reset();

      run_msg(1'b0, abc, 100, -1);
      run_msg(1'b1, abc, 100, -1);
      run_msg(1'b0, rand_msg(56), 100, -1);
      run_msg(1'b0, rand_msg(55), 100, -1);
      run_msg(1'b1, abc, 50, -1);

      run_msg(1'b1, rand_msg(200), 100, 7);
      apply_reset();
      run_msg(1'b0, abc, 100, -1);

      run_msg(1'b1, rand_msg(200), 80, 7);
      run_msg(1'b0, abc, 100, -1);
      run_msg(1'b0, rand_msg(100), 80, 7);
      run_msg(1'b1, abc, 100, -1);

      run_msg(1'b0, rand_msg(0), 100, -1);
      run_msg(1'b1, rand_msg(0), 100, -1);
      run_msg(1'b0, rand_msg(64), 70, -1);
      run_msg(1'b1, rand_msg(111), 70, -1);
      run_msg(1'b1, rand_msg(112), 70, -1);
      run_msg(1'b1, rand_msg(128), 70, -1);

      for (int t = 0; t < 16; t++) begin
         rm = $urandom_range(0, 1);
         rl = $urandom_range(0, 300);
         rr = $urandom_range(30, 100);
         run_msg(rm[0], rand_msg(rl), rr, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
